// File: rtl/axist_csr_responder_if.sv
// Register-bus handshake between the management master and the CSR responder.
// The master drives the request side; the responder drives waitreq and the read return.
interface axist_csr_responder_if;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wrdata;
  logic        i_wren;
  logic        i_rden;
  logic        o_master_waitreq;
  logic        o_master_readdatavalid;
  logic [31:0] o_master_readdata;

  modport master (
    output i_wr_addr, i_wrdata, i_wren, i_rden,
    input  o_master_waitreq, o_master_readdatavalid, o_master_readdata
  );

  modport slave (
    input  i_wr_addr, i_wrdata, i_wren, i_rden,
    output o_master_waitreq, o_master_readdatavalid, o_master_readdata
  );
endinterface

// File: rtl/axist_csr_responder.sv
// CSR responder for the AXI-ST leader/follower harness: control/delay registers,
// checker and link status, and coherent 8x32 read windows over the 256-bit capture buses.
module axist_csr_responder #(
  parameter logic [15:0] BASE_HI       = 16'h5000,
  parameter int unsigned RD_LATENCY    = 2,
  parameter logic [31:0] UNMAPPED_DATA = 32'h0000_0000
) (
  input  logic                  mgmt_clk,
  input  logic                  i_mgmt_rst,
  axist_csr_responder_if.slave  csr_bus,
  output logic [31:0]           o_l2f_tx_pkt_ctrl,
  output logic [31:0]           o_f2l_tx_pkt_ctrl,
  output logic [15:0]           o_delay_x,
  output logic [15:0]           o_delay_y,
  output logic [15:0]           o_delay_z,
  output logic                  o_axi_soft_rst,
  input  logic [3:0]            i_l2f_ckr_sts,
  input  logic [3:0]            i_f2l_ckr_sts,
  input  logic [3:0]            i_linkup_sts,
  input  logic [255:0]          i_l2f_dout_first,
  input  logic [255:0]          i_l2f_dout_last,
  input  logic [255:0]          i_l2f_din_first,
  input  logic [255:0]          i_l2f_din_last,
  input  logic [255:0]          i_f2l_dout_first,
  input  logic [255:0]          i_f2l_dout_last,
  input  logic [255:0]          i_f2l_din_first,
  input  logic [255:0]          i_f2l_din_last
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned NUM_WIN = 8;
  localparam int unsigned WIN_W   = 256;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rden_q;
  logic               wren_q;
  logic [31:0]        hold_q;
  logic [WIN_W-1:0]   shadow_q [NUM_WIN];
  logic [WIN_W-1:0]   win_bus  [NUM_WIN];

  logic               rd_rise;
  logic               wr_rise;
  logic               addr_hit;
  logic [15:0]        offset;
  logic               win_hit;
  logic [2:0]         win_idx;
  logic [2:0]         word_idx;
  logic [31:0]        rd_word;

  logic [31:0]        l2f_ctrl_nxt;
  logic [31:0]        f2l_ctrl_nxt;
  logic [15:0]        delay_x_nxt;
  logic [15:0]        delay_y_nxt;
  logic [15:0]        delay_z_nxt;
  logic               soft_rst_nxt;

  // Window index order: {f2l, din, last}
  assign win_bus[0] = i_l2f_dout_first;
  assign win_bus[1] = i_l2f_dout_last;
  assign win_bus[2] = i_l2f_din_first;
  assign win_bus[3] = i_l2f_din_last;
  assign win_bus[4] = i_f2l_dout_first;
  assign win_bus[5] = i_f2l_dout_last;
  assign win_bus[6] = i_f2l_din_first;
  assign win_bus[7] = i_f2l_din_last;

  assign rd_rise  = csr_bus.i_rden & ~rden_q;
  assign wr_rise  = csr_bus.i_wren & ~wren_q;
  assign addr_hit = (csr_bus.i_wr_addr[31:16] == BASE_HI);
  assign offset   = csr_bus.i_wr_addr[15:0];
  assign word_idx = offset[4:2];

  // Window decode: 32-byte aligned windows at 0x40xx..0x43xx and 0x50xx..0x53xx
  always_comb begin
    win_hit = 1'b0;
    win_idx = 3'd0;
    if (addr_hit && (offset[7:5] == 3'd0) && (offset[1:0] == 2'd0)) begin
      case (offset[15:8])
        8'h40: begin win_hit = 1'b1; win_idx = 3'd0; end
        8'h41: begin win_hit = 1'b1; win_idx = 3'd1; end
        8'h42: begin win_hit = 1'b1; win_idx = 3'd2; end
        8'h43: begin win_hit = 1'b1; win_idx = 3'd3; end
        8'h50: begin win_hit = 1'b1; win_idx = 3'd4; end
        8'h51: begin win_hit = 1'b1; win_idx = 3'd5; end
        8'h52: begin win_hit = 1'b1; win_idx = 3'd6; end
        8'h53: begin win_hit = 1'b1; win_idx = 3'd7; end
        default: ;
      endcase
    end
  end

  // Post-write register values; the read mux uses these so a same-cycle read sees the write
  always_comb begin
    l2f_ctrl_nxt = o_l2f_tx_pkt_ctrl;
    f2l_ctrl_nxt = o_f2l_tx_pkt_ctrl;
    delay_x_nxt  = o_delay_x;
    delay_y_nxt  = o_delay_y;
    delay_z_nxt  = o_delay_z;
    soft_rst_nxt = o_axi_soft_rst;
    if (wr_rise && addr_hit) begin
      case (offset)
        16'h1000: l2f_ctrl_nxt = csr_bus.i_wrdata;
        16'h1008: f2l_ctrl_nxt = csr_bus.i_wrdata;
        16'h2000: delay_x_nxt  = csr_bus.i_wrdata[15:0];
        16'h2004: delay_y_nxt  = csr_bus.i_wrdata[15:0];
        16'h2008: delay_z_nxt  = csr_bus.i_wrdata[15:0];
        16'h3000: soft_rst_nxt = csr_bus.i_wrdata[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = UNMAPPED_DATA;
    if (win_hit) begin
      if (word_idx == 3'd0) rd_word = win_bus[win_idx][31:0];
      else                  rd_word = shadow_q[win_idx][{word_idx, 5'd0} +: 32];
    end else if (addr_hit) begin
      case (offset)
        16'h1000: rd_word = l2f_ctrl_nxt;
        16'h1004: rd_word = {28'd0, i_l2f_ckr_sts};
        16'h1008: rd_word = f2l_ctrl_nxt;
        16'h100C: rd_word = {28'd0, i_f2l_ckr_sts};
        16'h1010: rd_word = {28'd0, i_linkup_sts};
        16'h2000: rd_word = {16'd0, delay_x_nxt};
        16'h2004: rd_word = {16'd0, delay_y_nxt};
        16'h2008: rd_word = {16'd0, delay_z_nxt};
        16'h3000: rd_word = {31'd0, soft_rst_nxt};
        default:  rd_word = UNMAPPED_DATA;
      endcase
    end
  end

  // Edge detectors reset high so a request held across reset is not seen as a new rise
  always_ff @(posedge mgmt_clk or posedge i_mgmt_rst) begin
    if (i_mgmt_rst) begin
      rden_q            <= 1'b1;
      wren_q            <= 1'b1;
      o_l2f_tx_pkt_ctrl <= 32'd0;
      o_f2l_tx_pkt_ctrl <= 32'd0;
      o_delay_x         <= 16'd0;
      o_delay_y         <= 16'd0;
      o_delay_z         <= 16'd0;
      o_axi_soft_rst    <= 1'b0;
    end else begin
      rden_q            <= csr_bus.i_rden;
      wren_q            <= csr_bus.i_wren;
      o_l2f_tx_pkt_ctrl <= l2f_ctrl_nxt;
      o_f2l_tx_pkt_ctrl <= f2l_ctrl_nxt;
      o_delay_x         <= delay_x_nxt;
      o_delay_y         <= delay_y_nxt;
      o_delay_z         <= delay_z_nxt;
      o_axi_soft_rst    <= soft_rst_nxt;
    end
  end

  // Read FSM: capture data at accept, wait out the latency, pulse valid once
  always_ff @(posedge mgmt_clk or posedge i_mgmt_rst) begin
    if (i_mgmt_rst) begin
      state_q                        <= S_IDLE;
      cnt_q                          <= '0;
      hold_q                         <= 32'd0;
      csr_bus.o_master_waitreq       <= 1'b0;
      csr_bus.o_master_readdatavalid <= 1'b0;
      csr_bus.o_master_readdata      <= 32'd0;
      for (int i = 0; i < NUM_WIN; i++) shadow_q[i] <= '0;
    end else begin
      csr_bus.o_master_readdatavalid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_rise) begin
            state_q                  <= S_WAIT;
            cnt_q                    <= LAT_M1;
            hold_q                   <= rd_word;
            csr_bus.o_master_waitreq <= 1'b1;
            if (win_hit && (word_idx == 3'd0)) shadow_q[win_idx] <= win_bus[win_idx];
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q                        <= S_RESP;
            csr_bus.o_master_readdatavalid <= 1'b1;
            csr_bus.o_master_readdata      <= hold_q;
            csr_bus.o_master_waitreq       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axist_csr_responder.sv
// Directed bench for axist_csr_responder: register access, windows, unmapped reads and reset mid-read.
module tb_axist_csr_responder;

  localparam int unsigned LAT = 2;

  logic mgmt_clk = 1'b0;
  logic i_mgmt_rst;
  logic [31:0]  l2f_ctrl, f2l_ctrl;
  logic [15:0]  dly_x, dly_y, dly_z;
  logic         soft_rst;
  logic [3:0]   l2f_sts, f2l_sts, linkup;
  logic [255:0] l2f_dout_first, l2f_dout_last, l2f_din_first, l2f_din_last;
  logic [255:0] f2l_dout_first, f2l_dout_last, f2l_din_first, f2l_din_last;

  int checks   = 0;
  int failures = 0;

  axist_csr_responder_if bus ();

  axist_csr_responder #(
    .BASE_HI(16'h5000), .RD_LATENCY(LAT), .UNMAPPED_DATA(32'h0000_0000)
  ) dut (
    .mgmt_clk(mgmt_clk), .i_mgmt_rst(i_mgmt_rst), .csr_bus(bus),
    .o_l2f_tx_pkt_ctrl(l2f_ctrl), .o_f2l_tx_pkt_ctrl(f2l_ctrl),
    .o_delay_x(dly_x), .o_delay_y(dly_y), .o_delay_z(dly_z),
    .o_axi_soft_rst(soft_rst),
    .i_l2f_ckr_sts(l2f_sts), .i_f2l_ckr_sts(f2l_sts), .i_linkup_sts(linkup),
    .i_l2f_dout_first(l2f_dout_first), .i_l2f_dout_last(l2f_dout_last),
    .i_l2f_din_first(l2f_din_first), .i_l2f_din_last(l2f_din_last),
    .i_f2l_dout_first(f2l_dout_first), .i_f2l_dout_last(f2l_dout_last),
    .i_f2l_din_first(f2l_din_first), .i_f2l_din_last(f2l_din_last)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge mgmt_clk);
    bus.i_wr_addr = addr; bus.i_wrdata = data; bus.i_wren = 1'b1;
    @(negedge mgmt_clk);
    bus.i_wren = 1'b0;
  endtask

  // Bounded read: returns data of the first valid, its latency and the total pulse count
  task automatic do_read(input logic [31:0] addr, input int hold, input logic also_wr,
                         output logic [31:0] data, output int lat, output int pulses,
                         output logic wait1);
    @(negedge mgmt_clk);
    bus.i_wr_addr = addr; bus.i_rden = 1'b1;
    if (also_wr) bus.i_wren = 1'b1;
    lat = -1; pulses = 0; data = 'x; wait1 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge mgmt_clk);
      bus.i_wren = 1'b0;
      if (i >= hold) bus.i_rden = 1'b0;
      if (i == 1) wait1 = bus.o_master_waitreq;
      if (bus.o_master_readdatavalid) begin
        pulses++;
        if (lat < 0) begin lat = i - 1; data = bus.o_master_readdata; end
      end
    end
  endtask

  task automatic test_reset();
    i_mgmt_rst = 1'b1;
    bus.i_wr_addr = '0; bus.i_wrdata = '0; bus.i_wren = 1'b0; bus.i_rden = 1'b0;
    l2f_sts = '0; f2l_sts = '0; linkup = '0;
    l2f_dout_first = '0; l2f_dout_last = '0; l2f_din_first = '0; l2f_din_last = '0;
    f2l_dout_first = {8{32'hCAFE_0001}}; f2l_dout_last = '0; f2l_din_first = '0;
    f2l_din_last = {8{32'h1234_5678}};
    repeat (3) @(negedge mgmt_clk);
    checks++;
    if ({l2f_ctrl, f2l_ctrl, dly_x, dly_y, dly_z, soft_rst} !== '0) begin
      failures++; $display("FAIL reset_regs got=%h req=0", {l2f_ctrl, f2l_ctrl, dly_x, dly_y, dly_z, soft_rst});
    end
    checks++;
    if ({bus.o_master_waitreq, bus.o_master_readdatavalid, bus.o_master_readdata} !== 34'd0) begin
      failures++; $display("FAIL reset_bus wait=%b valid=%b data=%h", bus.o_master_waitreq,
                           bus.o_master_readdatavalid, bus.o_master_readdata);
    end
    i_mgmt_rst = 1'b0;
    repeat (2) @(negedge mgmt_clk);
  endtask

  task automatic test_write_read();
    logic [31:0] d; int lat, np; logic w1;
    do_write(32'h5000_2008, 32'h0000_1770);
    checks++;
    if (dly_z !== 16'h1770) begin failures++; $display("FAIL delay_z_out got=%h req=1770", dly_z); end
    do_read(32'h5000_2008, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0000_1770 || np != 1) begin
      failures++; $display("FAIL delay_z_read data=%h pulses=%0d req=00001770/1", d, np);
    end
    do_read(32'h5000_2008, 3, 1'b0, d, lat, np, w1);
    checks++;
    if (np != 1) begin failures++; $display("FAIL hold_rden pulses=%0d req=1", np); end
    do_write(32'h5000_2004, 32'hABCD_1234);
    do_read(32'h5000_2004, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0000_1234 || dly_y !== 16'h1234) begin
      failures++; $display("FAIL delay_y_partial data=%h out=%h req=00001234/1234", d, dly_y);
    end
  endtask

  task automatic test_soft_rst_ro();
    logic [31:0] d; int lat, np; logic w1;
    do_write(32'h5000_3000, 32'h1);
    checks++;
    if (soft_rst !== 1'b1) begin failures++; $display("FAIL soft_rst_set got=%b req=1", soft_rst); end
    do_write(32'h5000_3000, 32'h0);
    checks++;
    if (soft_rst !== 1'b0) begin failures++; $display("FAIL soft_rst_clr got=%b req=0", soft_rst); end
    l2f_sts = 4'h5;
    do_write(32'h5000_1004, 32'hFFFF_FFFF);
    do_read(32'h5000_1004, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0000_0005) begin failures++; $display("FAIL ro_write_ignored got=%h req=00000005", d); end
  endtask

  task automatic test_status_latency();
    logic [31:0] d; int lat, np; logic w1;
    linkup = 4'hF;
    do_read(32'h5000_1010, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0000_000F) begin failures++; $display("FAIL linkup_data got=%h req=0000000F", d); end
    checks++;
    if (lat != LAT) begin failures++; $display("FAIL linkup_latency got=%0d req=%0d", lat, LAT); end
    checks++;
    if (w1 !== 1'b1 || bus.o_master_waitreq !== 1'b0) begin
      failures++; $display("FAIL waitreq during=%b after=%b req=1/0", w1, bus.o_master_waitreq);
    end
  endtask

  task automatic test_window();
    logic [31:0] d; int lat, np; logic w1;
    do_read(32'h5000_5304, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL shadow_before_w0 got=%h req=00000000", d); end
    l2f_dout_last = {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    do_read(32'h5000_4100, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h11) begin failures++; $display("FAIL window_w0 got=%h req=00000011", d); end
    l2f_dout_last = {8{32'hDEAD_BEEF}};
    for (int k = 1; k < 8; k++) begin
      do_read(32'h5000_4100 + 32'(4 * k), 1, 1'b0, d, lat, np, w1);
      checks++;
      if (d !== 32'(32'h11 * (k + 1))) begin
        failures++; $display("FAIL window_w%0d got=%h req=%h", k, d, 32'(32'h11 * (k + 1)));
      end
    end
  endtask

  task automatic test_same_cycle_unmapped();
    logic [31:0] d; int lat, np; logic w1;
    bus.i_wrdata = 32'h0000_0FF5;
    do_read(32'h5000_1000, 1, 1'b1, d, lat, np, w1);
    checks++;
    if (d !== 32'h0000_0FF5 || l2f_ctrl !== 32'h0000_0FF5) begin
      failures++; $display("FAIL same_cycle_wr_rd data=%h reg=%h req=00000FF5", d, l2f_ctrl);
    end
    do_read(32'h5000_6000, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0 || np != 1) begin failures++; $display("FAIL unmapped_off data=%h pulses=%0d req=0/1", d, np); end
    do_read(32'h6000_1000, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0 || np != 1) begin failures++; $display("FAIL base_mismatch data=%h pulses=%0d req=0/1", d, np); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; int lat, np; logic w1;
    int vcount;
    do_write(32'h5000_1008, 32'h0000_ABCD);
    do_write(32'h5000_3000, 32'h1);
    @(negedge mgmt_clk);
    bus.i_wr_addr = 32'h5000_1008; bus.i_rden = 1'b1;
    @(negedge mgmt_clk);
    i_mgmt_rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_master_waitreq, bus.o_master_readdatavalid, bus.o_master_readdata,
         l2f_ctrl, f2l_ctrl, dly_x, dly_y, dly_z, soft_rst} !== '0) begin
      failures++; $display("FAIL midread_rst_outs wait=%b valid=%b data=%h f2l=%h srst=%b",
                           bus.o_master_waitreq, bus.o_master_readdatavalid,
                           bus.o_master_readdata, f2l_ctrl, soft_rst);
    end
    vcount = 0;
    repeat (3) begin @(negedge mgmt_clk); if (bus.o_master_readdatavalid) vcount++; end
    i_mgmt_rst = 1'b0;
    repeat (4) begin @(negedge mgmt_clk); if (bus.o_master_readdatavalid) vcount++; end
    checks++;
    if (vcount != 0) begin failures++; $display("FAIL midread_no_valid pulses=%0d req=0", vcount); end
    bus.i_rden = 1'b0;
    do_read(32'h5000_1008, 1, 1'b0, d, lat, np, w1);
    checks++;
    if (d !== 32'h0 || np != 1) begin failures++; $display("FAIL post_rst_read data=%h pulses=%0d req=0/1", d, np); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_soft_rst_ro();
    test_status_latency();
    test_window();
    test_same_cycle_unmapped();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
